// File: rtl/mips16_pkg.sv
// Shared definitions for the mips16 multi-cycle controller: opcodes, FSM states,
// ALU and ALU-B select encodings, the control word and opcode classifiers.
package mips16_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_ADDI = 4'd4;
  localparam logic [3:0] OP_LW   = 4'd5;
  localparam logic [3:0] OP_SW   = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_BEQ  = 4'd8;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_ADDR   = 4'd2,
    S_MEM_RD = 4'd3,
    S_LW_WB  = 4'd4,
    S_MEM_WR = 4'd5,
    S_R_EXEC = 4'd6,
    S_R_WB   = 4'd7,
    S_BRANCH = 4'd8,
    S_I_WB   = 4'd9,
    S_HALT   = 4'd10
  } state_e;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_INC    = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       retire;
    logic       halted;
  } ctrl_t;

  function automatic logic is_rtype(input logic [3:0] op);
    return (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT});
  endfunction

  function automatic logic is_addr_op(input logic [3:0] op);
    return (op inside {OP_ADDI, OP_LW, OP_SW});
  endfunction

  function automatic logic is_legal(input logic [3:0] op);
    return is_rtype(op) || is_addr_op(op) || (op == OP_BEQ);
  endfunction

  // There is no funct field: R-type ALU operation comes straight from the opcode.
  function automatic logic [2:0] rtype_alu(input logic [3:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mips16_ctrl_decode.sv
// Combinational state+opcode -> control word decoder for the mips16 controller.
// MIPS16_ILLEGAL_TRAP_EN: HALT decodes to halted=1; otherwise illegal DECODE retires as NOP.
module mips16_ctrl_decode
  import mips16_pkg::*;
(
  input  state_e      i_state,
  input  logic [3:0]  i_opcode,
  input  logic        i_mem_ready,
  output ctrl_t       o_ctrl
);

  // Moore decode; only the memory-completion strobes look at mem_ready
  always_comb begin
    o_ctrl        = '0;
    o_ctrl.alu_op = ALU_ADD;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.alu_src_b = SRCB_INC;
        if (i_mem_ready) begin
          o_ctrl.ir_write = 1'b1;
          o_ctrl.pc_write = 1'b1;
        end else begin
          o_ctrl.ir_write = 1'b0;
          o_ctrl.pc_write = 1'b0;
        end
      end
      S_DECODE: begin
        o_ctrl.alu_src_b = SRCB_IMM_SH;
`ifndef MIPS16_ILLEGAL_TRAP_EN
        if (!is_legal(i_opcode)) begin
          o_ctrl.retire = 1'b1;
        end else begin
          o_ctrl.retire = 1'b0;
        end
`endif
      end
      S_ADDR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.iord     = 1'b1;
      end
      S_LW_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.retire     = 1'b1;
      end
      S_MEM_WR: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.iord      = 1'b1;
        o_ctrl.retire    = i_mem_ready;
      end
      S_R_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_REG;
        o_ctrl.alu_op    = rtype_alu(i_opcode);
      end
      S_R_WB: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.reg_dst   = 1'b1;
        o_ctrl.retire    = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_src_b     = SRCB_REG;
        o_ctrl.alu_op        = ALU_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_source     = 1'b1;
        o_ctrl.retire        = 1'b1;
      end
      S_I_WB: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.retire    = 1'b1;
      end
      S_HALT: begin
`ifdef MIPS16_ILLEGAL_TRAP_EN
        o_ctrl.halted = 1'b1;
`endif
      end
      default: begin
        o_ctrl = '0;
      end
    endcase
  end

endmodule

// File: rtl/mips16_mc_control.sv
// Multi-cycle control FSM for the 16-bit MIPS datapath (state register + next-state).
// MIPS16_ILLEGAL_TRAP_EN: undefined opcodes trap into HALT until reset.
module mips16_mc_control
  import mips16_pkg::*;
#(
  parameter int INC_CONST = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       pc_source,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [3:0] state,
  output logic       retire,
  output logic       halted
);

  state_e r_state;
  state_e w_next;
  ctrl_t  w_ctrl;
  ctrl_t  w_out;

  // zero and INC_CONST are consumed by the datapath; referenced here only as intentionally unused
  logic w_unused;
  assign w_unused = zero ^ (INC_CONST == 0);

  // State register with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH: begin
        if (mem_ready) w_next = S_DECODE;
        else           w_next = S_FETCH;
      end
      S_DECODE: begin
        if (is_rtype(opcode))        w_next = S_R_EXEC;
        else if (is_addr_op(opcode)) w_next = S_ADDR;
        else if (opcode == OP_BEQ)   w_next = S_BRANCH;
        else begin
`ifdef MIPS16_ILLEGAL_TRAP_EN
          w_next = S_HALT;
`else
          w_next = S_FETCH;
`endif
        end
      end
      S_ADDR: begin
        case (opcode)
          OP_LW:   w_next = S_MEM_RD;
          OP_SW:   w_next = S_MEM_WR;
          OP_ADDI: w_next = S_I_WB;
          default: w_next = S_FETCH;
        endcase
      end
      S_MEM_RD: begin
        if (mem_ready) w_next = S_LW_WB;
        else           w_next = S_MEM_RD;
      end
      S_MEM_WR: begin
        if (mem_ready) w_next = S_FETCH;
        else           w_next = S_MEM_WR;
      end
      S_R_EXEC: w_next = S_R_WB;
      S_LW_WB, S_R_WB, S_BRANCH, S_I_WB: w_next = S_FETCH;
      S_HALT: begin
`ifdef MIPS16_ILLEGAL_TRAP_EN
        w_next = S_HALT;
`else
        w_next = S_FETCH;
`endif
      end
      default: w_next = S_FETCH;
    endcase
  end

  mips16_ctrl_decode u_decode (
    .i_state     (r_state),
    .i_opcode    (opcode),
    .i_mem_ready (mem_ready),
    .o_ctrl      (w_ctrl)
  );

  // Reset kills every strobe in the cycle it is asserted, aborting any instruction
  assign w_out = reset_n ? w_ctrl : '0;
  assign state = reset_n ? 4'(r_state) : 4'd0;

  assign pc_write      = w_out.pc_write;
  assign pc_write_cond = w_out.pc_write_cond;
  assign pc_source     = w_out.pc_source;
  assign iord          = w_out.iord;
  assign mem_read      = w_out.mem_read;
  assign mem_write     = w_out.mem_write;
  assign ir_write      = w_out.ir_write;
  assign reg_dst       = w_out.reg_dst;
  assign mem_to_reg    = w_out.mem_to_reg;
  assign reg_write     = w_out.reg_write;
  assign alu_src_a     = w_out.alu_src_a;
  assign alu_src_b     = w_out.alu_src_b;
  assign alu_op        = w_out.alu_op;
  assign retire        = w_out.retire;
  assign halted        = w_out.halted;

endmodule

// File: tb/tb_mips16_mc_control.sv
// Scoreboard bench for mips16_mc_control: per-instruction reference sequences are
// expanded into per-cycle expectations, a monitor compares them mid-cycle.
module tb_mips16_mc_control;

  logic       clock = 1'b0;
  logic       reset_n, zero, mem_ready;
  logic [3:0] opcode;
  logic       pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a, retire, halted;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic [3:0] state;

  always #5 clock = ~clock;

  mips16_mc_control #(.INC_CONST(2)) dut (
    .clock(clock), .reset_n(reset_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .state(state), .retire(retire), .halted(halted)
  );

  typedef struct packed {
    logic       pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [3:0] state;
    logic       retire, halted;
  } ctl_t;

  typedef struct {
    logic       rst_n;
    logic [3:0] op;
    logic       z;
    logic       mr;
    ctl_t       e;
    ctl_t       c;
    int         tag;
  } stim_t;

  typedef struct {
    ctl_t e;
    ctl_t c;
    int   tag;
  } exp_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    instr_no = 0;
  int    zsel = -1;
  ctl_t  dut_v;

  assign dut_v = {pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write, ir_write,
                  reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, state,
                  retire, halted};

  task automatic push(input logic rn, input logic [3:0] op, input logic mr,
                      input ctl_t e, input ctl_t c);
    stim_t s;
    s.rst_n = rn; s.op = op; s.mr = mr; s.e = e; s.c = c; s.tag = instr_no;
    if (zsel < 0) s.z = 1'($urandom);
    else          s.z = 1'(zsel);
    stim_q.push_back(s);
  endtask

  // Every strobe and the state are always checked; selectors only where defined
  task automatic base(input logic [3:0] st, output ctl_t e, output ctl_t c);
    e = '0; c = '0;
    e.state = st; c.state = 4'hF;
    c.pc_write = 1'b1; c.pc_write_cond = 1'b1; c.mem_read = 1'b1; c.mem_write = 1'b1;
    c.ir_write = 1'b1; c.reg_write = 1'b1; c.retire = 1'b1; c.halted = 1'b1;
  endtask

  task automatic reset_cycle(input logic mr);
    ctl_t e, c;
    e = '0; c = '1;
    push(1'b0, 4'($urandom), mr, e, c);
  endtask

  function automatic logic [2:0] alu_for(input logic [3:0] op);
    case (op)
      4'd1:    return 3'b110;
      4'd2:    return 3'b000;
      4'd3:    return 3'b001;
      4'd7:    return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  // Expected cycle sequence of one instruction: fw fetch waits, mw memory waits
  task automatic gen_instr(input logic [3:0] op, input int fw, input int mw, input bit abort);
    ctl_t e, c;
    logic mr;
    instr_no++;
    for (int i = 0; i <= fw; i++) begin
      mr = (i == fw);
      base(4'd0, e, c);
      e.mem_read = 1'b1; c.iord = 1'b1; c.alu_src_a = 1'b1;
      e.alu_src_b = 2'b01; c.alu_src_b = 2'b11; e.alu_op = 3'b010; c.alu_op = 3'b111;
      e.ir_write = mr; e.pc_write = mr;
      push(1'b1, 4'($urandom), mr, e, c);
    end
    base(4'd1, e, c);
    c.alu_src_a = 1'b1; e.alu_src_b = 2'b11; c.alu_src_b = 2'b11;
    e.alu_op = 3'b010; c.alu_op = 3'b111;
`ifndef MIPS16_ILLEGAL_TRAP_EN
    if (op >= 4'd9) e.retire = 1'b1;
`endif
    push(1'b1, op, 1'($urandom), e, c);
    if (op >= 4'd9) begin
`ifdef MIPS16_ILLEGAL_TRAP_EN
      for (int i = 0; i < int'($urandom_range(2, 6)); i++) begin
        base(4'd10, e, c);
        e.halted = 1'b1;
        push(1'b1, op, 1'($urandom), e, c);
      end
      reset_cycle(1'($urandom));
`endif
      return;
    end
    if (op <= 4'd3 || op == 4'd7) begin
      base(4'd6, e, c);
      e.alu_src_a = 1'b1; c.alu_src_a = 1'b1; c.alu_src_b = 2'b11;
      e.alu_op = alu_for(op); c.alu_op = 3'b111;
      push(1'b1, op, 1'($urandom), e, c);
      base(4'd7, e, c);
      e.reg_write = 1'b1; e.reg_dst = 1'b1; c.reg_dst = 1'b1; c.mem_to_reg = 1'b1;
      e.retire = 1'b1;
      push(1'b1, op, 1'($urandom), e, c);
    end else if (op == 4'd8) begin
      base(4'd8, e, c);
      e.alu_src_a = 1'b1; c.alu_src_a = 1'b1; c.alu_src_b = 2'b11;
      e.alu_op = 3'b110; c.alu_op = 3'b111;
      e.pc_write_cond = 1'b1; e.pc_source = 1'b1; c.pc_source = 1'b1; e.retire = 1'b1;
      push(1'b1, op, 1'($urandom), e, c);
    end else begin
      base(4'd2, e, c);
      e.alu_src_a = 1'b1; c.alu_src_a = 1'b1; e.alu_src_b = 2'b10; c.alu_src_b = 2'b11;
      e.alu_op = 3'b010; c.alu_op = 3'b111;
      push(1'b1, op, 1'($urandom), e, c);
      if (op == 4'd4) begin
        base(4'd9, e, c);
        e.reg_write = 1'b1; c.reg_dst = 1'b1; c.mem_to_reg = 1'b1; e.retire = 1'b1;
        push(1'b1, op, 1'($urandom), e, c);
      end else if (abort) begin
        reset_cycle(1'b1);
      end else begin
        for (int i = 0; i <= mw; i++) begin
          mr = (i == mw);
          base((op == 4'd5) ? 4'd3 : 4'd5, e, c);
          e.iord = 1'b1; c.iord = 1'b1;
          if (op == 4'd5) e.mem_read = 1'b1;
          else begin
            e.mem_write = 1'b1;
            e.retire = mr;
          end
          push(1'b1, op, mr, e, c);
        end
        if (op == 4'd5) begin
          base(4'd4, e, c);
          e.reg_write = 1'b1; e.mem_to_reg = 1'b1; c.mem_to_reg = 1'b1; c.reg_dst = 1'b1;
          e.retire = 1'b1;
          push(1'b1, op, 1'($urandom), e, c);
        end
      end
    end
  endtask

  // Monitor: compare the DUT mid-cycle against the next queued expectation
  always @(negedge clock) begin : monitor
    exp_t x;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      vectors++;
      if (((dut_v ^ x.e) & x.c) != '0) begin
        miscompares++;
        $display("FAIL ctl instr %0d state %0d: got %h expected %h (checked bits %h)",
                 x.tag, state, dut_v, x.e, x.c);
      end
    end
  end

  initial begin
    stim_t s;
    exp_t  x;
    reset_n = 1'b0; opcode = 4'd0; zero = 1'b0; mem_ready = 1'b1;
    repeat (3) reset_cycle(1'b1);
    gen_instr(4'd0, 0, 0, 1'b0);
    gen_instr(4'd5, 0, 2, 1'b0);
    zsel = 1; gen_instr(4'd8, 0, 0, 1'b0);
    zsel = 0; gen_instr(4'd8, 0, 0, 1'b0);
    zsel = -1;
    gen_instr(4'd15, 0, 0, 1'b0);
    gen_instr(4'd6, 0, 0, 1'b1);
    gen_instr(4'd6, 1, 1, 1'b0);
    gen_instr(4'd1, 2, 0, 1'b0);
    gen_instr(4'd7, 0, 0, 1'b0);
    repeat (150) gen_instr(4'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
                           ($urandom_range(0, 15) == 0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      @(posedge clock);
      #1;
      reset_n = s.rst_n; opcode = s.op; zero = s.z; mem_ready = s.mr;
      x.e = s.e; x.c = s.c; x.tag = s.tag;
      exp_q.push_back(x);
    end
    for (int k = 0; k < 4 && exp_q.size() != 0; k++) @(negedge clock);
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mips16_mc_control.md
# mips16_mc_control

Multi-cycle control FSM for the 16-bit MIPS datapath: add, sub, and, or, slt, addi, lw, sw, beq. It sequences instruction fetch, decode, execute, memory access and writeback over several clock cycles. It drives the PC, IR, register-file, ALU-mux and memory strobes of a shared-memory multi-cycle datapath. It sits beside the datapath and sees only the opcode field `IR[15:12]` and a memory-ready handshake.

## Interface
- `INC_CONST`, default 2: PC increment selected by `alu_src_b`=01, used in FETCH.
- `clock`  in  1  sole clock; all state changes on its rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `opcode`  in  4  `IR[15:12]` from the IR register (valid from DECODE onward)
- `zero`  in  1  ALU zero flag
- `mem_ready`  in  1  memory completes the current read/write this cycle
- `pc_write`  out  1  unconditional PC load
- `pc_write_cond`  out  1  PC load if `zero`
- `pc_source`  out  1  0 = ALU result, 1 = ALUOut register (branch target)
- `iord`  out  1  memory address: 0 = PC, 1 = ALUOut
- `mem_read`  out  1  memory read request
- `mem_write`  out  1  memory write request
- `ir_write`  out  1  load IR from memory data
- `reg_dst`  out  1  write register: 0 = `IR[9:8]`, 1 = `IR[7:6]`
- `mem_to_reg`  out  1  write data: 0 = ALUOut, 1 = MDR
- `reg_write`  out  1  register-file write enable
- `alu_src_a`  out  1  0 = PC, 1 = register A
- `alu_src_b`  out  2  00 = B, 01 = `INC_CONST`, 10 = sign-extended imm, 11 = sign-extended imm << 1
- `alu_op`  out  3  ALU op: 010 add, 110 sub, 000 and, 001 or, 111 slt
- `state`  out  4  current state encoding (debug)
- `retire`  out  1  one-cycle pulse in an instruction's final cycle
- `halted`  out  1  illegal-opcode trap state (only with the macro)

## Operation
- Outputs are Moore-decoded from `state`, except that `pc_write`, `ir_write` and `retire` in memory states are qualified by `mem_ready`.
- ALU op per instruction:
  - add/addi/lw/sw address: 010
  - sub/beq: 110
  - and: 000
  - or: 001
  - slt: 111
  - R-type ALU op is derived from `opcode` directly; there is no funct field.
- States and transitions:
  - FETCH (0): `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=010. While `mem_ready`=0, stay. When `mem_ready`=1, assert `ir_write`+`pc_write` and go to DECODE.
  - DECODE (1): `alu_src_a`=0, `alu_src_b`=11, `alu_op`=010 (branch target into ALUOut). Next state: R-type (0000, 0001, 0010, 0011, 0111) → R_EXEC; 0100/0101/0110 → ADDR; 1000 → BRANCH; any other → illegal handling.
  - ADDR (2): `alu_src_a`=1, `alu_src_b`=10, `alu_op`=010. Next state: lw → MEM_RD; sw → MEM_WR; addi → I_WB.
  - MEM_RD (3): `mem_read`=1, `iord`=1. Hold until `mem_ready`, then go to LW_WB.
  - LW_WB (4): `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0, `retire`=1. Next: FETCH.
  - MEM_WR (5): `mem_write`=1, `iord`=1. Hold until `mem_ready`; assert `retire` on completion, then go to FETCH.
  - R_EXEC (6): `alu_src_a`=1, `alu_src_b`=00, `alu_op` from opcode. Next: R_WB.
  - R_WB (7): `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0, `retire`=1. Next: FETCH.
  - BRANCH (8): `alu_src_a`=1, `alu_src_b`=00, `alu_op`=110, `pc_write_cond`=1, `pc_source`=1, `retire`=1. Next: FETCH.
  - I_WB (9): `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0, `retire`=1. Next: FETCH.
  - HALT (10): all strobes 0, `halted`=1. Leaves only on reset.
- Writes to register $0 are the register file's concern; the controller does not suppress them.

## Timing
- Reset: with `reset_n`=0 at a rising edge, state becomes FETCH. While `reset_n`=0, every output is forced to 0 (`state` reads 0, `halted`=0).
- A reset asserted mid-instruction aborts it: no `reg_write`, `mem_write` or PC strobe is issued in that cycle or afterwards.
- Latency with zero-wait memory, counted from FETCH entry to return to FETCH: R-type 4, addi 4, sw 4, lw 5, beq 3. Each wait cycle of `mem_ready`=0 adds 1.
- Request handshake: `mem_read`/`mem_write`/`iord` stay stable from state entry until the cycle with `mem_ready`=1. `mem_ready` is ignored in non-memory states.
- `retire` pulses exactly once per completed instruction.

## Configuration
- `MIPS16_ILLEGAL_TRAP_EN` defined: an undefined opcode in DECODE goes to HALT, and `halted` is held at 1 until reset.
- Not defined: an undefined opcode is a NOP. DECODE → FETCH with `retire`=1, HALT is unreachable, and `halted` is tied to 0.

## Structure
- Shared package `mips16_pkg` holds:
  - opcode constants (OP_ADD..OP_BEQ)
  - the state enum
  - ALU op encodings
  - `alu_src_b` select encodings
- One sub-module, `mips16_ctrl_decode`: combinational state+opcode → control-word decoder. The FSM register and next-state logic live in the top.

## Test plan
- Reset held 3 cycles, then released with `mem_ready`=1 → all outputs 0 during reset; FETCH with `mem_read`=1, `ir_write`=1, `pc_write`=1 on the first cycle after release.
- opcode=0000 (add), zero-wait → states 0,1,6,7; R_WB has `reg_write`=1, `reg_dst`=1, `alu_op`=010; `retire` once; 4 cycles.
- opcode=0101 (lw), `mem_ready` low 2 cycles in MEM_RD → `mem_read`+`iord` held 3 cycles, LW_WB has `mem_to_reg`=1; 7 cycles total.
- opcode=1000 (beq), `zero`=1 then `zero`=0 → BRANCH asserts `pc_write_cond`=1, `pc_source`=1, `alu_op`=110; 3 cycles each.
- opcode=1111 → with the macro, `halted`=1 and state=10 persist until `reset_n`=0; without it, a 2-cycle NOP with `retire`=1.
- `reset_n`=0 in MEM_WR while `mem_ready`=1 → no `mem_write` or `retire` that cycle; FETCH after release.
